// File: rtl/led_scan_ctrl.sv
// Eight-digit seven-segment scan controller.
// Shadow/active registers give tear-free updates at frame boundaries.
module led_scan_ctrl #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    output logic [2:0]  cs_pointer,
    output logic [7:0]  seg,
    output logic        blank,
    output logic        frame_done
);

    localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DW_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BL_LAST = TW'(BLANK_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DWELL = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [31:0]   pend_data, act_data, nxt_data;
    logic [7:0]    pend_dp, act_dp, nxt_dp;
    logic [7:0]    pend_en, act_en, nxt_en;
    logic          dwell_end, blank_end, start;
    logic [2:0]    nxt_ptr;
    logic [7:0]    seg_next;

    function automatic logic [7:0] encode(
        input logic [31:0] d,
        input logic [7:0]  m_dp,
        input logic [7:0]  m_en,
        input logic [2:0]  p
    );
        logic [3:0] nib;
        logic [6:0] s;
        nib = d[{p, 2'b00} +: 4];
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return m_en[p] ? {m_dp[p], s} : 8'h00;
    endfunction

    assign dwell_end = (state == S_DWELL) && (timer == DW_LAST);
    assign blank_end = (state == S_BLANK) && (timer == BL_LAST);
    assign start     = (state == S_IDLE) || (blank_end && cs_pointer == 3'd7);
    assign nxt_ptr   = (state == S_IDLE) ? 3'd0 : cs_pointer + 3'd1;

    // A load on the frame-start edge bypasses the shadow and goes straight to active.
    always_comb begin
        nxt_data = act_data;
        nxt_dp   = act_dp;
        nxt_en   = act_en;
        if (start) begin
            nxt_data = load ? data     : pend_data;
            nxt_dp   = load ? dp       : pend_dp;
            nxt_en   = load ? digit_en : pend_en;
        end
    end

    assign seg_next = encode(nxt_data, nxt_dp, nxt_en, nxt_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            cs_pointer <= 3'd0;
            seg        <= 8'h00;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            act_en     <= '0;
        end else begin
            frame_done <= 1'b0;
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp;
                pend_en   <= digit_en;
            end
            if (!en) begin
                state      <= S_IDLE;
                timer      <= '0;
                cs_pointer <= 3'd0;
                seg        <= 8'h00;
                blank      <= 1'b1;
            end else begin
                act_data <= nxt_data;
                act_dp   <= nxt_dp;
                act_en   <= nxt_en;
                case (state)
                    S_IDLE: begin
                        state      <= S_DWELL;
                        timer      <= '0;
                        cs_pointer <= 3'd0;
                        seg        <= seg_next;
                        blank      <= 1'b0;
                    end
                    S_DWELL: begin
                        if (dwell_end) begin
                            state <= S_BLANK;
                            timer <= '0;
                            seg   <= 8'h00;
                            blank <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_BLANK: begin
                        if (blank_end) begin
                            state      <= S_DWELL;
                            timer      <= '0;
                            cs_pointer <= nxt_ptr;
                            seg        <= seg_next;
                            blank      <= 1'b0;
                            frame_done <= start;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule
